icache_sa: RTL and testbench

//  Parametrised set-associative, read-only instruction cache between IF stage and memory fabric.

---
 rtl/icache_sa.sv | 182 ++++++++++++++++++
 tb/tb_icache_sa.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_sa.sv
// icache_sa: set-associative read-only I-cache (TLB tag handshake, multi-beat refill, FENCE.I flush); ICACHE_PLRU_EN selects tree pseudo-LRU over round-robin
module icache_sa #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int LINE_BYTES  = 64,
  parameter int WAYS        = 4,
  parameter int SETS        = 64,
  parameter int BEAT_WIDTH  = 128,
  localparam int TAG_W = ADDR_WIDTH - $clog2(LINE_BYTES) - $clog2(SETS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   cpu_req_valid_i,
  output logic                   cpu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr_i,
  input  logic                   tlb_valid_i,
  output logic                   tlb_ready_o,
  input  logic [TAG_W-1:0]       tlb_pa_tag_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [INSTR_WIDTH-1:0] resp_instr_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr_o,
  input  logic                   mem_rvalid_i,
  input  logic [BEAT_WIDTH-1:0]  mem_rdata_i
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int NBEATS = LINE_W / BEAT_WIDTH;
  localparam int BC_W   = NBEATS > 1 ? $clog2(NBEATS) : 1;
  localparam int WB_W   = $clog2(INSTR_WIDTH / 8);
  localparam int WSEL_W = OFF_W - WB_W;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(NBEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_RESP, S_MISS_REQ, S_REFILL} state_t;

  state_t                       r_state, w_next;
  logic [IDX_W-1:0]             r_idx;
  logic [WSEL_W-1:0]            r_word;
  logic [TAG_W-1:0]             r_tag;
  logic [BC_W-1:0]              r_beat;
  logic [INSTR_WIDTH-1:0]       r_instr;
  logic                         r_flush_pend;
  logic [SETS-1:0][WAYS-1:0]    r_valid;
  logic [LINE_W-1:0]            r_buf;
  logic [LINE_W-1:0]            r_data [SETS][WAYS];
  logic [TAG_W-1:0]             r_tags [SETS][WAYS];
  logic [LINE_W-1:0]            w_line;
  logic [WAYS-1:0]              w_hit_vec;
  logic [WAY_W-1:0]             w_hit_way, w_inv_way, w_repl_way, w_victim;
  logic                         w_all_valid, w_hit_acc, w_last_beat, w_drop, w_fill, w_flush_now;
  logic                         w_unused;

  assign w_all_valid = &r_valid[r_idx];
  assign w_hit_acc   = r_state == S_LOOKUP && tlb_valid_i && !flush_i && |w_hit_vec;
  assign w_last_beat = r_state == S_REFILL && mem_rvalid_i && r_beat == LAST_BEAT;
  assign w_drop      = w_last_beat && (r_flush_pend || flush_i);
  assign w_fill      = w_last_beat && !w_drop;
  assign w_flush_now = flush_i && (r_state == S_IDLE || r_state == S_LOOKUP || r_state == S_RESP);
  assign w_victim    = w_all_valid ? w_repl_way : w_inv_way;
  assign w_unused    = ^{cpu_addr_i[ADDR_WIDTH-1:OFF_W+IDX_W], cpu_addr_i[WB_W-1:0], r_buf[LINE_W-1 -: BEAT_WIDTH]};

  assign cpu_req_ready_o = r_state == S_IDLE && !flush_i;
  assign tlb_ready_o     = r_state == S_LOOKUP && !flush_i;
  assign resp_valid_o    = r_state == S_RESP && !flush_i;
  assign resp_instr_o    = r_instr;
  assign mem_req_valid_o = r_state == S_MISS_REQ;
  assign mem_req_addr_o  = {r_tag, r_idx, {OFF_W{1'b0}}};

  // Parallel tag compare, hit-way encode and lowest-invalid-way search for the registered set
  always_comb begin
    w_hit_vec = '0;
    w_hit_way = '0;
    w_inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_valid[r_idx][w] && r_tags[r_idx][w] == tlb_pa_tag_i;
      if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!r_valid[r_idx][w]) w_inv_way = WAY_W'(w);
  end

  // Complete line as seen on the last beat: buffered beats plus the beat on the bus
  always_comb begin
    w_line = r_buf;
    w_line[LINE_W-1 -: BEAT_WIDTH] = mem_rdata_i;
  end

  // Next-state logic; a flush aborts every state except an in-flight refill
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = cpu_req_valid_i && !flush_i ? S_LOOKUP : S_IDLE;
      S_LOOKUP:   w_next = flush_i ? S_IDLE : !tlb_valid_i ? S_LOOKUP : |w_hit_vec ? S_RESP : S_MISS_REQ;
      S_RESP:     w_next = flush_i || resp_ready_i ? S_IDLE : S_RESP;
      S_MISS_REQ: w_next = mem_req_ready_i ? S_REFILL : S_MISS_REQ;
      S_REFILL:   w_next = !w_last_beat ? S_REFILL : w_drop ? S_IDLE : S_RESP;
      default:    w_next = S_IDLE;
    endcase
  end

  // Control state, request fields, response word and valid bits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_word       <= '0;
      r_tag        <= '0;
      r_beat       <= '0;
      r_instr      <= '0;
      r_flush_pend <= 1'b0;
      r_valid      <= '0;
    end else begin
      r_state <= w_next;
      if (cpu_req_valid_i && cpu_req_ready_o) {r_idx, r_word} <= cpu_addr_i[OFF_W+IDX_W-1:WB_W];
      if (tlb_valid_i && tlb_ready_o) r_tag <= tlb_pa_tag_i;
      if (r_state == S_REFILL && mem_rvalid_i) r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      if (w_hit_acc) r_instr <= r_data[r_idx][w_hit_way][r_word*INSTR_WIDTH +: INSTR_WIDTH];
      else if (w_fill) r_instr <= w_line[r_word*INSTR_WIDTH +: INSTR_WIDTH];
      if (w_last_beat) r_flush_pend <= 1'b0;
      else if (flush_i && (r_state == S_MISS_REQ || r_state == S_REFILL)) r_flush_pend <= 1'b1;
      if (w_flush_now || w_drop) r_valid <= '0;
      else if (w_fill) r_valid[r_idx][w_victim] <= 1'b1;
    end
  end

  // Line buffer and data/tag arrays carry no reset; validity is tracked separately
  always_ff @(posedge clk_i) begin
    if (r_state == S_REFILL && mem_rvalid_i) r_buf[r_beat*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata_i;
    if (w_fill) begin
      r_data[r_idx][w_victim] <= w_line;
      r_tags[r_idx][w_victim] <= r_tag;
    end
  end

`ifdef ICACHE_PLRU_EN
  logic [SETS-1:0][WAYS-2:0] r_plru;

  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] t);
    int n;
    n = 1;
    for (int l = 0; l < WAY_W; l++) n = 2 * n + int'(t[n-1]);
    return WAY_W'(n - WAYS);
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t, input logic [WAY_W-1:0] a);
    int n;
    n = 1;
    for (int l = 0; l < WAY_W; l++) begin
      t[n-1] = ~a[WAY_W-1-l];
      n = 2 * n + int'(a[WAY_W-1-l]);
    end
    return t;
  endfunction

  assign w_repl_way = plru_victim(r_plru[r_idx]);

  // Tree bits steer away from the way just hit or filled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_plru <= '0;
    else if (w_hit_acc) r_plru[r_idx] <= plru_touch(r_plru[r_idx], w_hit_way);
    else if (w_fill) r_plru[r_idx] <= plru_touch(r_plru[r_idx], w_victim);
  end
`else
  logic [SETS-1:0][WAY_W-1:0] r_rr;

  assign w_repl_way = r_rr[r_idx];

  // Round-robin pointer advances only when a fill had to evict a valid line
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_rr <= '0;
    else if (w_fill && w_all_valid) r_rr[r_idx] <= r_rr[r_idx] + 1'b1;
  end
`endif

  a_one_hit: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state == S_LOOKUP && tlb_valid_i) |-> $onehot0(w_hit_vec));
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed bench for icache_sa with a fabric model serving 4-beat line refills
module tb_icache_sa;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         flush_i = 1'b0;
  logic         cpu_req_valid_i = 1'b0;
  logic         cpu_req_ready_o;
  logic [31:0]  cpu_addr_i = '0;
  logic         tlb_valid_i = 1'b0;
  logic         tlb_ready_o;
  logic [19:0]  tlb_pa_tag_i = '0;
  logic         resp_valid_o;
  logic         resp_ready_i = 1'b0;
  logic [31:0]  resp_instr_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [31:0]  mem_req_addr_o;
  logic         mem_rvalid_i;
  logic [127:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;
  int mem_reqs = 0;
  int beats_left = 0;
  int beats_done = 0;
  int cur_beat = 0;
  int req_delay = 0;
  int wait_n = 0;
  logic [31:0] req_addr = '0;
  logic [31:0] hold_addr = '0;

  icache_sa dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .cpu_req_valid_i(cpu_req_valid_i), .cpu_req_ready_o(cpu_req_ready_o), .cpu_addr_i(cpu_addr_i),
    .tlb_valid_i(tlb_valid_i), .tlb_ready_o(tlb_ready_o), .tlb_pa_tag_i(tlb_pa_tag_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_instr_o(resp_instr_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wexp(input logic [31:0] a);
    return 32'hC0DE0000 ^ {a[31:2], 2'b00};
  endfunction

  // Fabric: optional request stall, then 4 consecutive beats, ascending addresses
  initial begin
    mem_req_ready_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (rst_i) begin
        beats_left = 0;
        wait_n = 0;
      end else if (mem_req_valid_o) begin
        if (wait_n > 0) check("mreq_addr_hold", mem_req_addr_o, hold_addr);
        hold_addr = mem_req_addr_o;
        if (wait_n < req_delay) wait_n++;
        else begin
          mem_req_ready_i = 1'b1;
          wait_n = 0;
          mem_reqs++;
          req_addr = mem_req_addr_o;
          beats_left = 4;
        end
      end else if (beats_left > 0) begin
        cur_beat = 4 - beats_left;
        mem_rvalid_i = 1'b1;
        for (int k = 0; k < 4; k++)
          mem_rdata_i[32*k +: 32] = 32'hC0DE0000 ^ (req_addr + 32'(16 * cur_beat + 4 * k));
        beats_left--;
        beats_done++;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input int hold, output logic [31:0] instr, output int lat);
    int n;
    @(negedge clk_i);
    cpu_req_valid_i = 1'b1;
    cpu_addr_i = a;
    tlb_valid_i = 1'b1;
    tlb_pa_tag_i = a[31:12];
    n = 0;
    while (!cpu_req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    cpu_req_valid_i = 1'b0;
    lat = 1;
    while (!resp_valid_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
    instr = resp_instr_o;
    if (resp_valid_o) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk_i);
        check("resp_hold_valid", resp_valid_o, 1);
        check("resp_hold_instr", resp_instr_o, instr);
      end
      resp_ready_i = 1'b1;
      @(negedge clk_i);
      resp_ready_i = 1'b0;
    end
    tlb_valid_i = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [31:0] a, input bit miss);
    logic [31:0] instr;
    int lat;
    int m0;
    m0 = mem_reqs;
    fetch(a, 0, instr, lat);
    check({tag, "_instr"}, instr, wexp(a));
    check({tag, "_lat"}, lat, miss ? 7 : 2);
    check({tag, "_mreqs"}, mem_reqs - m0, miss ? 1 : 0);
    if (miss) check({tag, "_maddr"}, req_addr, {a[31:6], 6'b0});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, cpu_req_ready_o, 1);
    check({tag, "_tlb_ready"}, tlb_ready_o, 0);
    check({tag, "_resp_valid"}, resp_valid_o, 0);
    check({tag, "_resp_instr"}, resp_instr_o, 0);
    check({tag, "_mreq_valid"}, mem_req_valid_o, 0);
    check({tag, "_mreq_addr"}, mem_req_addr_o, 0);
  endtask

  initial begin
    logic [31:0] instr;
    int lat, m0, b0, n;
    bit saw;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst");
    rst_i = 1'b0;

    probe("cold", 32'h0000_1008, 1);
    probe("rehit", 32'h0000_1008, 0);
    probe("hit4", 32'h0000_1004, 0);
    probe("lowbits", 32'h0000_1003, 0);
    probe("lastword", 32'h0000_103C, 0);

    probe("fill2", 32'h0000_2000, 1);
    probe("fill3", 32'h0000_3000, 1);
    probe("fill4", 32'h0000_4000, 1);
    probe("evict5", 32'h0000_5000, 1);
    probe("keep2", 32'h0000_2000, 0);
    probe("gone1", 32'h0000_1000, 1);
    probe("keep3", 32'h0000_3000, 0);
    probe("gone2", 32'h0000_2000, 1);

    req_delay = 3;
    m0 = mem_reqs;
    fetch(32'h0000_6044, 5, instr, lat);
    req_delay = 0;
    check("bp_instr", instr, wexp(32'h0000_6044));
    check("bp_lat", lat, 10);
    check("bp_mreqs", mem_reqs - m0, 1);
    probe("bp_hit", 32'h0000_6048, 0);

    m0 = mem_reqs;
    b0 = beats_done;
    @(negedge clk_i);
    cpu_req_valid_i = 1'b1;
    cpu_addr_i = 32'h0000_7000;
    tlb_valid_i = 1'b1;
    tlb_pa_tag_i = 20'h7;
    @(negedge clk_i);
    cpu_req_valid_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk_i);
      #1;
      n++;
    end while (!(mem_rvalid_i && cur_beat == 2) && n < 50);
    check("fl_reach_beat2", n < 50, 1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk_i);
      if (resp_valid_o) saw = 1'b1;
    end
    tlb_valid_i = 1'b0;
    check("fl_no_resp", saw, 0);
    check("fl_beats", beats_done - b0, 4);
    check("fl_mreqs", mem_reqs - m0, 1);
    check("fl_idle", cpu_req_ready_o, 1);
    probe("fl_miss6", 32'h0000_6040, 1);
    probe("fl_miss3", 32'h0000_3000, 1);
    probe("fl_miss7", 32'h0000_7000, 1);

    @(negedge clk_i);
    flush_i = 1'b1;
    cpu_req_valid_i = 1'b1;
    cpu_addr_i = 32'h0000_7000;
    #1;
    check("idle_fl_ready", cpu_req_ready_o, 0);
    @(negedge clk_i);
    flush_i = 1'b0;
    cpu_req_valid_i = 1'b0;
    #1;
    check("idle_fl_no_lookup", tlb_ready_o, 0);
    probe("idle_fl_miss7", 32'h0000_7000, 1);

    @(negedge clk_i);
    cpu_req_valid_i = 1'b1;
    cpu_addr_i = 32'h0000_8000;
    tlb_valid_i = 1'b1;
    tlb_pa_tag_i = 20'h8;
    @(negedge clk_i);
    cpu_req_valid_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk_i);
      #1;
      n++;
    end while (!mem_rvalid_i && n < 50);
    check("ar_reach_refill", n < 50, 1);
    tlb_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("ar");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    probe("ar_miss8", 32'h0000_8000, 1);
    probe("ar_miss6", 32'h0000_6048, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
